measure_rx_stats: RTL and testbench
===================================

Name: measure_rx_stats

Overview:
Receive-side measurement stage for one GMII port. It sits directly downstream of the PHY receive pins and directly upstream of the PCI register bank, which only reads its results. It parses incoming frames, counts frames and bytes per one-second window, and extracts the embedded transmit timestamp and source IPv4 address from measurement frames. Results are the rx1_pps, rx1_throughput, rx1_latency and rx1_ipv4_ip values exposed over BAR0.

Parameters:
SEC_CYCLES, 125000000, sys_clk cycles per statistics window (1 s at 125 MHz).
MAGIC, 32'h3776_0000, signature at frame bytes 42-45 marking a measurement frame.
MIN_LEN, 64, minimum counted frame length in bytes, FCS included.

Ports:
sys_clk  in  1  GMII receive clock; the only clock.
sys_rst  in  1  reset, asynchronous, active-low.
gmii_rx_dv  in  1  receive data valid.
gmii_rx_er  in  1  receive error.
gmii_rxd  in  8  receive data.
global_counter  in  32  free-running timestamp in the sys_clk domain; the same time base the transmitter embeds in frames.
rx_pps  out  32  frames in the last completed window.
rx_throughput  out  32  bytes in the last completed window.
rx_latency  out  24  latency of the last valid measurement frame, in cycles.
rx_ipv4_ip  out  32  source IPv4 address of the last valid measurement frame.
rx_frame_valid  out  1  one-cycle pulse when rx_latency and rx_ipv4_ip update.

Behaviour:
- Reset (sys_rst=0, async): all outputs 0; FSM to IDLE; window counter, accumulators and byte counter 0. Reset mid-frame discards the frame.
- All inputs are sampled on the sys_clk rising edge. All outputs are registered.
- FSM states:
  - IDLE: when dv=1 and rxd=0x55, go to PREAMBLE. When dv=1 and rxd is anything else, go to DROP.
  - PREAMBLE: 0x55 stays. 0xD5 goes to DATA, latches sfd_ts<=global_counter and clears byte_cnt. Any other byte, dv=0 or er=1 goes to DROP (or IDLE if dv=0).
  - DATA: each dv=1 cycle stores the byte at index byte_cnt, then byte_cnt+1. byte_cnt is 16-bit and saturates at 16'hFFFF. er=1 goes to DROP. dv=0 completes the frame and returns to IDLE.
  - DROP: wait for dv=0, then IDLE; nothing is counted.
- Field capture (byte index from first byte after SFD, big-endian):
  - ethertype from bytes 12-13.
  - src IP from bytes 26-29.
  - signature from bytes 42-45.
  - tx timestamp from bytes 46-49.
- Frame completion is the first dv=0 cycle in DATA.
  - Good frame: byte_cnt >= MIN_LEN. Adds 1 to frame_acc and byte_cnt to byte_acc.
  - Measurement frame: good frame with ethertype 16'h0800 and signature==MAGIC.
    - diff = sfd_ts - tx_ts, modulo 2^32 (wrap-around is legal).
    - rx_latency = diff[31:24]!=0 ? 24'hFFFFFF : diff[23:0].
    - rx_ipv4_ip = src IP.
    - rx_frame_valid = 1 on the following cycle.
    - Non-measurement frames leave rx_latency and rx_ipv4_ip unchanged (sticky across windows).
- Window:
  - win_cnt counts 0..SEC_CYCLES-1 and wraps.
  - On the win_cnt==SEC_CYCLES-1 cycle, rx_pps<=frame_acc and rx_throughput<=byte_acc; both accumulators restart.
  - If a frame completes in that same cycle, it is excluded from the latched values and its contribution seeds the new window (acc <= contribution, not 0).
  - Accumulators saturate at 32'hFFFFFFFF.
- Latency is valid only when the transmitter's timestamp uses the same global_counter domain; the block makes no clock-offset correction.

Test Plan:
1. Hold sys_rst=0, drive dv=1 with data -> all outputs 0. Release reset -> outputs stay 0 until the first window end or first measurement frame.
2. 64-byte measurement frame: 7x55, D5, ethertype 0800, src IP 0A001469, MAGIC at bytes 42-45, tx_ts 0x00000100; global_counter=0x00000164 at the SFD cycle -> one cycle after dv falls, rx_latency=0x000064, rx_ipv4_ip=0x0A001469, rx_frame_valid pulses once.
3. SEC_CYCLES=1000: five good 64-byte frames in window 1, none in window 2 -> rx_pps=5, rx_throughput=320 after window 1; both 0 after window 2.
4. gmii_rx_er=1 at byte 30 of a measurement frame -> not counted in pps or throughput; rx_latency, rx_ipv4_ip unchanged; no rx_frame_valid pulse. A 60-byte runt -> also not counted.
5. Latency arithmetic: tx_ts=0xFFFFFFF0, sfd_ts=0x00000010 -> rx_latency=0x000020. tx_ts=0, sfd_ts=0x01000005 -> rx_latency=0xFFFFFF.
6. Frame completion coinciding with win_cnt==SEC_CYCLES-1, with 3 earlier frames in the window -> rx_pps=3; next window's rx_pps includes that frame (1 if no others).

Source files
------------

// File: rtl/measure_rx_stats.sv
// GMII receive measurement stage: per-window frame/byte counts plus
// latency and source IP taken from embedded measurement frames.
module measure_rx_stats #(
  parameter int unsigned SEC_CYCLES = 125000000,
  parameter logic [31:0] MAGIC      = 32'h3776_0000,
  parameter int unsigned MIN_LEN    = 64
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  input  logic [7:0]  gmii_rxd,
  input  logic [31:0] global_counter,
  output logic [31:0] rx_pps,
  output logic [31:0] rx_throughput,
  output logic [23:0] rx_latency,
  output logic [31:0] rx_ipv4_ip,
  output logic        rx_frame_valid
);

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    DATA,
    DROP
  } state_t;

  state_t      state;
  logic [15:0] byte_cnt;
  logic [15:0] ethertype;
  logic [31:0] src_ip;
  logic [31:0] sig;
  logic [31:0] tx_ts;
  logic [31:0] sfd_ts;
  logic [31:0] win_cnt;
  logic [31:0] frame_acc;
  logic [31:0] byte_acc;

  logic        done;
  logic        good;
  logic        meas;
  logic        win_end;
  logic [31:0] diff;
  logic [31:0] add_f;
  logic [31:0] add_b;
  logic [32:0] sum_f;
  logic [32:0] sum_b;
  logic        in_et;
  logic        in_ip;
  logic        in_sig;
  logic        in_ts;

  assign done    = (state == DATA) && !gmii_rx_dv;
  assign good    = done && (byte_cnt >= 16'(MIN_LEN));
  assign meas    = good && (ethertype == 16'h0800)
                   && (sig == MAGIC);
  assign win_end = (win_cnt == 32'(SEC_CYCLES - 1));
  assign diff    = sfd_ts - tx_ts;
  assign add_f   = {31'd0, good};
  assign add_b   = good ? {16'd0, byte_cnt} : 32'd0;
  assign sum_f   = {1'b0, frame_acc} + {1'b0, add_f};
  assign sum_b   = {1'b0, byte_acc} + {1'b0, add_b};

  assign in_et  = (byte_cnt >= 16'd12) && (byte_cnt <= 16'd13);
  assign in_ip  = (byte_cnt >= 16'd26) && (byte_cnt <= 16'd29);
  assign in_sig = (byte_cnt >= 16'd42) && (byte_cnt <= 16'd45);
  assign in_ts  = (byte_cnt >= 16'd46) && (byte_cnt <= 16'd49);

  // Frame parser; header fields are shifted in big-endian.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state     <= IDLE;
      byte_cnt  <= 16'd0;
      ethertype <= 16'd0;
      src_ip    <= 32'd0;
      sig       <= 32'd0;
      tx_ts     <= 32'd0;
      sfd_ts    <= 32'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (gmii_rx_dv)
            state <= (gmii_rxd == 8'h55) ? PREAMBLE : DROP;
        end
        PREAMBLE: begin
          if (!gmii_rx_dv) begin
            state <= IDLE;
          end else if (gmii_rx_er) begin
            state <= DROP;
          end else if (gmii_rxd == 8'hD5) begin
            state    <= DATA;
            sfd_ts   <= global_counter;
            byte_cnt <= 16'd0;
          end else if (gmii_rxd != 8'h55) begin
            state <= DROP;
          end
        end
        DATA: begin
          if (!gmii_rx_dv) begin
            state <= IDLE;
          end else if (gmii_rx_er) begin
            state <= DROP;
          end else begin
            if (byte_cnt != 16'hFFFF)
              byte_cnt <= byte_cnt + 16'd1;
            unique case (1'b1)
              in_et:   ethertype <= {ethertype[7:0], gmii_rxd};
              in_ip:   src_ip <= {src_ip[23:0], gmii_rxd};
              in_sig:  sig <= {sig[23:0], gmii_rxd};
              in_ts:   tx_ts <= {tx_ts[23:0], gmii_rxd};
              default: ;
            endcase
          end
        end
        DROP: begin
          if (!gmii_rx_dv)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A frame finishing on the window's last cycle seeds the next window.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      win_cnt       <= 32'd0;
      frame_acc     <= 32'd0;
      byte_acc      <= 32'd0;
      rx_pps        <= 32'd0;
      rx_throughput <= 32'd0;
    end else if (win_end) begin
      win_cnt       <= 32'd0;
      rx_pps        <= frame_acc;
      rx_throughput <= byte_acc;
      frame_acc     <= add_f;
      byte_acc      <= add_b;
    end else begin
      win_cnt   <= win_cnt + 32'd1;
      frame_acc <= sum_f[32] ? 32'hFFFF_FFFF : sum_f[31:0];
      byte_acc  <= sum_b[32] ? 32'hFFFF_FFFF : sum_b[31:0];
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      rx_latency     <= 24'd0;
      rx_ipv4_ip     <= 32'd0;
      rx_frame_valid <= 1'b0;
    end else begin
      rx_frame_valid <= meas;
      if (meas) begin
        rx_latency <= (|diff[31:24]) ? 24'hFF_FFFF : diff[23:0];
        rx_ipv4_ip <= src_ip;
      end
    end
  end

endmodule

// File: tb/tb_measure_rx_stats.sv
// Bench for measure_rx_stats: directed latency table, window corner
// cases and random frames against a frame-level reference model.
module tb_measure_rx_stats;

  localparam int unsigned SEC = 1000;
  localparam logic [31:0] MAGIC = 32'h3776_0000;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic        gmii_rx_dv = 1'b0;
  logic        gmii_rx_er = 1'b0;
  logic [7:0]  gmii_rxd = 8'h00;
  logic [31:0] global_counter = 32'd0;
  logic [31:0] rx_pps;
  logic [31:0] rx_throughput;
  logic [23:0] rx_latency;
  logic [31:0] rx_ipv4_ip;
  logic        rx_frame_valid;

  measure_rx_stats #(
    .SEC_CYCLES(SEC),
    .MAGIC(MAGIC),
    .MIN_LEN(64)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .gmii_rx_dv(gmii_rx_dv),
    .gmii_rx_er(gmii_rx_er),
    .gmii_rxd(gmii_rxd),
    .global_counter(global_counter),
    .rx_pps(rx_pps),
    .rx_throughput(rx_throughput),
    .rx_latency(rx_latency),
    .rx_ipv4_ip(rx_ipv4_ip),
    .rx_frame_valid(rx_frame_valid)
  );

  always #4 sys_clk = ~sys_clk;

  int n_chk = 0;
  int n_fail = 0;
  int edge_n = 0;
  bit chk_win = 1'b0;
  int vcnt = 0;
  int exp_vcnt = 0;
  logic [23:0] exp_lat = 24'd0;
  logic [31:0] exp_ip = 32'd0;
  longint unsigned win_f [0:63];
  longint unsigned win_b [0:63];

  typedef struct {
    logic [31:0] tx;
    logic [31:0] sfd;
    logic [23:0] lat;
  } lat_vec_t;

  lat_vec_t tbl [5];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [23:0] lat_of(input logic [31:0] sfd,
                                         input logic [31:0] tx);
    logic [31:0] d;
    d = sfd - tx;
    return (d >= 32'h0100_0000) ? 24'hFF_FFFF : d[23:0];
  endfunction

  always @(posedge sys_clk)
    if (sys_rst) edge_n <= edge_n + 1;

  always @(negedge sys_clk)
    if (sys_rst && rx_frame_valid) vcnt++;

  // Window results appear just after edge k*SEC-1.
  always @(negedge sys_clk) begin
    if (chk_win && edge_n > 0 && (edge_n % SEC) == 0) begin
      chk("win_pps", rx_pps, 32'(win_f[edge_n / SEC - 1]));
      chk("win_bytes", rx_throughput, 32'(win_b[edge_n / SEC - 1]));
    end
  end

  task automatic drive(input logic [7:0] b, input logic e);
    @(negedge sys_clk);
    gmii_rx_dv = 1'b1;
    gmii_rxd = b;
    gmii_rx_er = e;
  endtask

  task automatic send_frame(input int len, input bit meas,
                            input logic [31:0] ip,
                            input logic [31:0] tx,
                            input logic [31:0] sfd,
                            input int er_at, input int gap);
    logic [7:0] f [0:255];
    int cpl;
    int w;
    bit pulse;
    for (int i = 0; i < 256; i++) f[i] = 8'($urandom);
    f[12] = meas ? 8'h08 : 8'h86;
    f[13] = meas ? 8'h00 : 8'hDD;
    for (int i = 0; i < 4; i++) begin
      f[26 + i] = ip[31 - 8*i -: 8];
      f[42 + i] = MAGIC[31 - 8*i -: 8];
      f[46 + i] = tx[31 - 8*i -: 8];
    end
    global_counter = sfd;
    for (int i = 0; i < 7; i++) drive(8'h55, 1'b0);
    drive(8'hD5, 1'b0);
    for (int i = 0; i < len; i++) drive(f[i], i == er_at);
    @(negedge sys_clk);
    gmii_rx_dv = 1'b0;
    gmii_rx_er = 1'b0;
    gmii_rxd = 8'h00;
    cpl = edge_n;
    pulse = 1'b0;
    if (er_at < 0 && len >= 64) begin
      w = (cpl + 1) / SEC;
      win_f[w] += 1;
      win_b[w] += longint'(len);
      if (meas) begin
        exp_lat = lat_of(sfd, tx);
        exp_ip = ip;
        exp_vcnt++;
        pulse = 1'b1;
      end
    end
    @(negedge sys_clk);
    chk("latency", {8'd0, rx_latency}, {8'd0, exp_lat});
    chk("ipv4_ip", rx_ipv4_ip, exp_ip);
    chk("frame_valid", {31'd0, rx_frame_valid}, {31'd0, pulse});
    repeat (gap) @(negedge sys_clk);
  endtask

  task automatic wait_edge(input int n);
    while (edge_n < n) @(negedge sys_clk);
  endtask

  initial begin
    tbl[0] = '{32'h0000_0100, 32'h0000_0164, 24'h00_0064};
    tbl[1] = '{32'hFFFF_FFF0, 32'h0000_0010, 24'h00_0020};
    tbl[2] = '{32'h0000_0000, 32'h0100_0005, 24'hFF_FFFF};
    tbl[3] = '{32'h1234_5678, 32'h1234_5678, 24'h00_0000};
    tbl[4] = '{32'h0000_0010, 32'h0000_000F, 24'hFF_FFFF};
    for (int i = 0; i < 64; i++) begin
      win_f[i] = 0;
      win_b[i] = 0;
    end

    // Traffic during reset must not disturb anything.
    repeat (10) begin
      @(negedge sys_clk);
      gmii_rx_dv = 1'b1;
      gmii_rxd = 8'($urandom);
    end
    chk("rst_pps", rx_pps, 32'd0);
    chk("rst_bytes", rx_throughput, 32'd0);
    chk("rst_lat", {8'd0, rx_latency}, 32'd0);
    chk("rst_ip", rx_ipv4_ip, 32'd0);
    chk("rst_valid", {31'd0, rx_frame_valid}, 32'd0);
    gmii_rx_dv = 1'b0;
    @(negedge sys_clk);
    sys_rst = 1'b1;
    chk_win = 1'b1;
    repeat (5) @(negedge sys_clk);
    chk("post_rst_pps", rx_pps, 32'd0);
    chk("post_rst_lat", {8'd0, rx_latency}, 32'd0);

    // Window 0: one measurement frame, four plain frames, then drops.
    send_frame(64, 1'b1, 32'h0A00_1469, 32'h0000_0100,
               32'h0000_0164, -1, 10);
    chk("t2_lat", {8'd0, rx_latency}, 32'h0000_0064);
    chk("t2_ip", rx_ipv4_ip, 32'h0A00_1469);
    for (int i = 0; i < 4; i++)
      send_frame(64, 1'b0, 32'h0, 32'h0, 32'h0, -1, 10);
    send_frame(64, 1'b1, 32'hC0A8_0001, 32'h0, 32'h5, 30, 10);
    send_frame(60, 1'b1, 32'hC0A8_0002, 32'h0, 32'h7, -1, 10);
    chk("t4_lat", {8'd0, rx_latency}, 32'h0000_0064);
    chk("t4_ip", rx_ipv4_ip, 32'h0A00_1469);
    wait_edge(SEC);
    chk("t3_pps_w0", rx_pps, 32'd5);
    chk("t3_bytes_w0", rx_throughput, 32'd320);
    wait_edge(2 * SEC);
    chk("t3_pps_w1", rx_pps, 32'd0);
    chk("t3_bytes_w1", rx_throughput, 32'd0);

    // Window 2: latency arithmetic table.
    foreach (tbl[i]) begin
      send_frame(64, 1'b1, 32'h0A00_0100 + i, tbl[i].tx,
                 tbl[i].sfd, -1, 8);
      chk("tbl_lat", {8'd0, rx_latency}, {8'd0, tbl[i].lat});
    end

    // Window 3: fourth frame completes on the window's last cycle.
    wait_edge(3 * SEC);
    for (int i = 0; i < 3; i++)
      send_frame(64, 1'b0, 32'h0, 32'h0, 32'h0, -1, 5);
    wait_edge(4 * SEC - 74);
    send_frame(64, 1'b0, 32'h0, 32'h0, 32'h0, -1, 0);
    wait_edge(4 * SEC);
    chk("t6_pps", rx_pps, 32'd3);
    wait_edge(5 * SEC);
    chk("t6_pps_next", rx_pps, 32'd1);
    chk("t6_bytes_next", rx_throughput, 32'd64);

    // Random traffic against the frame-level model.
    for (int k = 0; k < 40; k++) begin
      int len;
      int er;
      logic [31:0] tx;
      len = $urandom_range(56, 120);
      er = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len - 1) : -1;
      tx = $urandom;
      send_frame(len, 1'($urandom), $urandom, tx,
                 tx + $urandom_range(0, 32'h01FF_FFFF), er,
                 $urandom_range(1, 20));
    end
    wait_edge((edge_n / SEC + 2) * SEC);
    @(negedge sys_clk);
    chk("valid_pulses", vcnt, exp_vcnt);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
